// File: rtl/bram_rd_stream_pkg.sv
// Shared types and helpers for the block-RAM read stream controller.
package bram_rd_stream_pkg;

   // Widest RAM word the FIFO entry can carry; narrower words are zero-extended.
   localparam int C_MAX_DATA_W = 64;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic                    last;
      logic [C_MAX_DATA_W-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/bram_rd_stream_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count output.
module bram_rd_stream_fifo import bram_rd_stream_pkg::*; #(
   parameter  int WIDTH = 33,
   parameter  int DEPTH = 8,
   localparam int PW    = clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             full;
   logic             do_pop;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign do_pop = pop && !empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Stale storage is hidden while empty so the stream side reads zero.
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // The upstream credit scheme must never push into a full FIFO.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/bram_rd_stream_ctrl.sv
// Drains a burst from the block RAM read port into a valid/ready stream.
// Optional last-word marking is enabled by defining BRAM_RD_STREAM_CTRL_LAST_EN.
module bram_rd_stream_ctrl import bram_rd_stream_pkg::*; #(
   parameter  int C_RAM_RD_WIDTH = 32,
   parameter  int C_RAM_RD_DEPTH = 512,
   parameter  int C_RD_LATENCY   = 3,
   parameter  int C_FIFO_DEPTH   = 8,
   localparam int AW             = clog2(C_RAM_RD_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [AW-1:0]             base_addr,
   input  logic [AW:0]               num_words,
   output logic                      busy,
   output logic                      done,
   output logic [AW-1:0]             ram_rdAddr,
   output logic                      ram_rden,
   input  logic [C_RAM_RD_WIDTH-1:0] ram_dout,
   output logic                      dout_valid,
   input  logic                      dout_ready,
   output logic [C_RAM_RD_WIDTH-1:0] dout_data,
   output logic                      dout_last
);

   localparam int CW = clog2(C_FIFO_DEPTH) + 1;
   localparam int IW = clog2(C_RD_LATENCY + 1);
   localparam int SW = ((CW > IW) ? CW : IW) + 1;

   state_t                  state;
   state_t                  state_next;
   logic [AW-1:0]           rd_addr;
   logic [AW:0]             remaining;
   logic [C_RD_LATENCY-1:0] vld_sr;
   logic [IW-1:0]           in_flight;
   logic [CW-1:0]           fifo_count;
   logic [SW-1:0]           occupancy;
   logic                    fifo_empty;
   logic                    issue;
   logic                    issue_last;
   logic                    exit_valid;
   logic                    exit_last;
   logic                    pop;
   fifo_entry_t             push_entry;
   fifo_entry_t             pop_entry;

   // Reads in the RAM pipeline already own a FIFO slot, so they count against credit.
   assign in_flight  = IW'($countones(vld_sr));
   assign occupancy  = SW'(fifo_count) + SW'(in_flight);
   assign issue      = (state == ISSUE) && (remaining != '0) && (occupancy < SW'(C_FIFO_DEPTH));
   assign issue_last = issue && (remaining == (AW+1)'(1));
   assign exit_valid = vld_sr[C_RD_LATENCY-1];
   assign pop        = dout_valid && dout_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // DRAIN looks one cycle ahead so done lands right after the final handshake.
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      ram_rden   = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = (num_words == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            ram_rden = 1'b1;
            if (issue_last) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            ram_rden = 1'b1;
            if ((in_flight == '0) &&
                ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr   <= '0;
         remaining <= '0;
         vld_sr    <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            rd_addr   <= base_addr;
            remaining <= num_words;
         end else if (issue) begin
            rd_addr   <= rd_addr + 1'b1;
            remaining <= remaining - 1'b1;
         end
         vld_sr <= C_RD_LATENCY'({vld_sr, issue});
      end
   end

`ifdef BRAM_RD_STREAM_CTRL_LAST_EN
   logic [C_RD_LATENCY-1:0] last_sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_sr <= '0;
      end else begin
         last_sr <= C_RD_LATENCY'({last_sr, issue_last});
      end
   end

   assign exit_last = last_sr[C_RD_LATENCY-1];
   assign dout_last = pop_entry.last;
`else
   assign exit_last = 1'b0;
   assign dout_last = 1'b0;
`endif

   always_comb begin
      push_entry      = '0;
      push_entry.data = C_MAX_DATA_W'(ram_dout);
      push_entry.last = exit_last;
   end

   bram_rd_stream_fifo #(
      .WIDTH ($bits(fifo_entry_t)),
      .DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (exit_valid),
      .wr_data (push_entry),
      .pop     (pop),
      .rd_data (pop_entry),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign ram_rdAddr = rd_addr;
   assign dout_valid = !fifo_empty;
   assign dout_data  = pop_entry.data[C_RAM_RD_WIDTH-1:0];

endmodule
